// File: rtl/led_frame_scheduler.sv
// rtl/led_frame_scheduler.sv - round-robin frame scheduler for the LED serial sender
// Define LED_SCHED_REFRESH_EN to build the periodic auto-refresh of the last frame.
module led_frame_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 128,
    parameter int GAP_CYC     = 64,
    parameter int REFRESH_CYC = 1500000,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic                        tx_enable,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  active_id,
    output logic                        timeout_err,
    input  logic                        clr_err
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam int GW  = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYC < 1 || TIMEOUT_CYC < 1 || REFRESH_CYC < 2) begin : g_param_err
            $error("led_frame_scheduler: parameter out of range");
        end
    endgenerate

    state_t              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                tx_enable_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic [IDW-1:0]      active_id_q;
    logic                timeout_err_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [TW-1:0]       wdog_q;
    logic [GW-1:0]       gap_q;
    logic                frame_req_q;

    logic                win_found;
    logic [IDW-1:0]      win_idx;
    logic [IDW-1:0]      cand_idx;
    logic [IDW-1:0]      rr_ptr_d;
    int                  cand;

    // Rotating priority search: first requester at or after the pointer wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(rr_ptr_q) + k) % NUM_REQ;
            cand_idx = IDW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        rr_ptr_d = IDW'((int'(win_idx) + 1) % NUM_REQ);
    end

`ifdef LED_SCHED_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYC + 1);
    localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYC - 1);

    logic           have_last_q;
    logic [RW-1:0]  refresh_cnt_q;
    logic           refresh_due;

    // The count parks at its last value, so refresh_due stays up until the next ISSUE.
    assign refresh_due = have_last_q && (refresh_cnt_q == RF_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_last_q   <= 1'b0;
            refresh_cnt_q <= '0;
        end else begin
            if (state_q == S_IDLE && win_found) begin
                have_last_q <= 1'b1;
            end
            if (state_q == S_ISSUE) begin
                refresh_cnt_q <= '0;
            end else if (have_last_q && refresh_cnt_q != RF_LAST) begin
                refresh_cnt_q <= refresh_cnt_q + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            done_q        <= '0;
            tx_enable_q   <= 1'b0;
            tx_data_q     <= '0;
            active_id_q   <= '0;
            timeout_err_q <= 1'b0;
            rr_ptr_q      <= '0;
            wdog_q        <= '0;
            gap_q         <= '0;
            frame_req_q   <= 1'b0;
        end else begin
            gnt_q       <= '0;
            done_q      <= '0;
            tx_enable_q <= 1'b0;
            // A watchdog expiry later in this block overrides the clear.
            if (clr_err) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        tx_data_q      <= req_data[win_idx*DATA_W +: DATA_W];
                        active_id_q    <= win_idx;
                        rr_ptr_q       <= rr_ptr_d;
                        gnt_q[win_idx] <= 1'b1;
                        tx_enable_q    <= 1'b1;
                        frame_req_q    <= 1'b1;
                        state_q        <= S_ISSUE;
                    end
`ifdef LED_SCHED_REFRESH_EN
                    else if (refresh_due) begin
                        tx_enable_q <= 1'b1;
                        frame_req_q <= 1'b0;
                        state_q     <= S_ISSUE;
                    end
`endif
                end
                S_ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        wdog_q  <= '0;
                        state_q <= S_WAIT_DONE;
                    end else if (wdog_q == TO_LAST) begin
                        timeout_err_q <= 1'b1;
                        gap_q         <= '0;
                        state_q       <= S_GAP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (frame_req_q) begin
                            done_q[active_id_q] <= 1'b1;
                        end
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else if (wdog_q == TO_LAST) begin
                        timeout_err_q <= 1'b1;
                        gap_q         <= '0;
                        state_q       <= S_GAP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign tx_enable   = tx_enable_q;
    assign tx_data     = tx_data_q;
    assign active_id   = active_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb/tb_led_frame_scheduler.sv - directed self-checking bench for led_frame_scheduler
module tb_led_frame_scheduler;
    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 128;
    localparam int GAP_CYC     = 16;
    localparam int REFRESH_CYC = 1000;
    localparam int TIMEOUT_CYC = 300;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         done;
    logic                       tx_enable;
    logic [DATA_W-1:0]          tx_data;
    logic                       tx_busy;
    logic [1:0]                 active_id;
    logic                       timeout_err;
    logic                       clr_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_txen   = 0;
    int t_prev;
    int w;
    int pulses;
    logic [127:0] pay [4];

    led_frame_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .GAP_CYC     (GAP_CYC),
        .REFRESH_CYC (REFRESH_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .tx_enable   (tx_enable),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .active_id   (active_id),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_txen(input string tag, input int bound, output int waited);
        waited = 0;
        while (tx_enable !== 1'b1 && waited < bound) begin
            @(negedge clk);
            waited++;
        end
        t_txen = cyc;
        check(tag, tx_enable, 1'b1);
    endtask

    task automatic finish_frame(input string tag, input int busy_len, input logic [3:0] exp_done);
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        check({tag, "_busy"}, done, 4'b0000);
        tx_busy = 1'b0;
        @(negedge clk);
        check(tag, done, exp_done);
    endtask

    initial begin
        pay[0] = 128'hE1FF0000_E100FF00_E10000FF_FF123456;
        pay[1] = 128'h11111111_22222222_33333333_44444444;
        pay[2] = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
        pay[3] = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = {pay[3], pay[2], pay[1], pay[0]};
        tx_busy  = 1'b0;
        clr_err  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_done", done, 4'b0000);
        check("rst_txen", tx_enable, 1'b0);
        check("rst_txdata", tx_data, 128'h0);
        check("rst_active", active_id, 2'd0);
        check("rst_err", timeout_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_txen", tx_enable, 1'b0);

        // Single request, exact one-cycle grant latency
        req = 4'b0001;
        @(negedge clk);
        check("t1_gnt", gnt, 4'b0001);
        check("t1_txen", tx_enable, 1'b1);
        check("t1_txdata", tx_data, pay[0]);
        check("t1_active", active_id, 2'd0);
        req = 4'b0000;
        @(negedge clk);
        check("t1_gnt_pulse", gnt, 4'b0000);
        check("t1_txen_pulse", tx_enable, 1'b0);
        finish_frame("t1_done", 200, 4'b0001);
        req = 4'b1000;
        @(negedge clk);
        check("t1_done_pulse", done, 4'b0000);
        wait_txen("t1b_txen", 100, w);
        check("t1_gap_len", w, GAP_CYC);
        check("t1b_gnt", gnt, 4'b1000);
        check("t1b_txdata", tx_data, pay[3]);
        check("t1b_active", active_id, 2'd3);
        req = 4'b0000;
        finish_frame("t1b_done", 5, 4'b1000);

        // Fairness with all requesters held
        req = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            wait_txen("fair_txen", 100, w);
            check("fair_gnt", gnt, 4'b0001 << (f % 4));
            check("fair_data", tx_data, pay[f % 4]);
            if (f == 7) req = 4'b0000;
            finish_frame("fair_done", 5, 4'b0001 << (f % 4));
        end

        // Late arrivals during the gap: 2 then 3
        req = 4'b0010;
        wait_txen("t3a_txen", 100, w);
        check("t3a_gnt", gnt, 4'b0010);
        req = 4'b0000;
        finish_frame("t3a_done", 5, 4'b0010);
        repeat (2) @(negedge clk);
        req[2] = 1'b1;
        repeat (3) @(negedge clk);
        req[3] = 1'b1;
        wait_txen("t3b_txen", 100, w);
        check("t3b_gnt", gnt, 4'b0100);
        check("t3b_data", tx_data, pay[2]);
        req[2] = 1'b0;
        finish_frame("t3b_done", 5, 4'b0100);
        wait_txen("t3c_txen", 100, w);
        check("t3c_gnt", gnt, 4'b1000);
        req = 4'b0000;
        finish_frame("t3c_done", 5, 4'b1000);

        // Sender never starts
        req = 4'b0001;
        wait_txen("t4_txen", 100, w);
        check("t4_gnt", gnt, 4'b0001);
        req = 4'b0000;
        repeat (TIMEOUT_CYC) @(negedge clk);
        check("t4_err_early", timeout_err, 1'b0);
        @(negedge clk);
        check("t4_err_set", timeout_err, 1'b1);
        check("t4_no_done", done, 4'b0000);
        req = 4'b0010;
        wait_txen("t4b_txen", 100, w);
        check("t4_gap_len", w, GAP_CYC + 1);
        check("t4b_gnt", gnt, 4'b0010);
        req = 4'b0000;
        check("t4_err_sticky", timeout_err, 1'b1);
        finish_frame("t4b_done", 5, 4'b0010);
        clr_err = 1'b1;
        @(negedge clk);
        check("t4_err_clr", timeout_err, 1'b0);
        clr_err = 1'b0;

        // Reset in the middle of WAIT_DONE
        req = 4'b0100;
        wait_txen("t5_txen", 100, w);
        check("t5_gnt", gnt, 4'b0100);
        req = 4'b0000;
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_txdata", tx_data, 128'h0);
        check("t5_rst_active", active_id, 2'd0);
        check("t5_rst_txen", tx_enable, 1'b0);
        check("t5_rst_gnt", gnt, 4'b0000);
        @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        check("t5_rst_done", done, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        check("t5_no_reissue", tx_enable, 1'b0);
        req = 4'b1111;
        @(negedge clk);
        t_txen = cyc;
        check("t5_gnt_after", gnt, 4'b0001);
        check("t5_data_after", tx_data, pay[0]);
        req = 4'b0000;
        finish_frame("t5_done", 5, 4'b0001);

`ifdef LED_SCHED_REFRESH_EN
        // Refresh of the last frame, then a request racing a due refresh
        t_prev = t_txen;
        wait_txen("rf_txen", 2000, w);
        check("rf_period", t_txen - t_prev, REFRESH_CYC + 1);
        check("rf_no_gnt", gnt, 4'b0000);
        check("rf_data", tx_data, pay[0]);
        finish_frame("rf_no_done", 5, 4'b0000);
        t_prev = t_txen;
        while (cyc < t_prev + REFRESH_CYC) @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        check("rf_req_wins_gnt", gnt, 4'b0010);
        check("rf_req_wins_data", tx_data, pay[1]);
        req = 4'b0000;
        finish_frame("rf_req_done", 5, 4'b0010);
`else
        pulses = 0;
        repeat (REFRESH_CYC + 200) begin
            @(negedge clk);
            if (tx_enable === 1'b1) pulses++;
        end
        check("no_refresh", pulses, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
